tx_tdm_frame_scheduler: RTL and testbench

- Time-division scheduler that places the four 16-bit audio sample streams feeding the transmitter datapath onto one shared 16-bit channel word stream.
- Each frame is one sync word followed by fixed slots for channels 0..3. An empty slot is filled with a fill word and flagged as an underrun.
- Sits between the four per-channel sample sources and the noisy-channel modulator or serializer.

---
 rtl/tx_tdm_frame_scheduler.sv | 121 ++++++++++++
 tb/tb_tx_tdm_frame_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tx_tdm_frame_scheduler.sv
// TDM frame scheduler: one sync word followed by one slot for each of four sample
// channels. An empty slot sends a fill word and raises that channel's sticky underrun flag.
module tx_tdm_frame_scheduler #(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] SYNC_WORD = 16'hA5A5,
    parameter logic [DATA_W-1:0] FILL_WORD = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [3:0]        in_valid,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    output logic [3:0]        in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic [1:0]        out_slot,
    input  logic              out_ready,
    output logic [15:0]       frame_cnt,
    output logic [3:0]        underrun,
    input  logic              clr_status
);

    typedef enum logic [1:0] {IDLE, SYNC, SLOT} state_t;

    state_t            state, state_nxt;
    logic [1:0]        idx, idx_nxt;
    logic              load_en;
    logic              valid_nxt, sof_nxt;
    logic [DATA_W-1:0] data_nxt, sel_data;
    logic [1:0]        slot_nxt;
    logic [15:0]       cnt_nxt;
    logic [3:0]        underrun_set, underrun_nxt;

    assign load_en = !out_valid || out_ready;

    always_comb begin
        sel_data = in_data0;
        case (idx)
            2'd0: sel_data = in_data0;
            2'd1: sel_data = in_data1;
            2'd2: sel_data = in_data2;
            2'd3: sel_data = in_data3;
            default: sel_data = in_data0;
        endcase
    end

    // The FSM and the output register advance together, and only on load_en,
    // so backpressure stalls the frame exactly where it is.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        valid_nxt    = out_valid;
        data_nxt     = out_data;
        sof_nxt      = out_sof;
        slot_nxt     = out_slot;
        cnt_nxt      = frame_cnt;
        in_ready     = 4'b0000;
        underrun_set = 4'b0000;
        if (load_en) begin
            case (state)
                IDLE: begin
                    valid_nxt = 1'b0;
                    if (enable) state_nxt = SYNC;
                end
                SYNC: begin
                    data_nxt  = SYNC_WORD;
                    sof_nxt   = 1'b1;
                    slot_nxt  = 2'd0;
                    valid_nxt = 1'b1;
                    cnt_nxt   = frame_cnt + 16'd1;
                    idx_nxt   = 2'd0;
                    state_nxt = SLOT;
                end
                SLOT: begin
                    sof_nxt   = 1'b0;
                    slot_nxt  = idx;
                    valid_nxt = 1'b1;
                    in_ready  = 4'b0001 << idx;
                    if (in_valid[idx]) begin
                        data_nxt = sel_data;
                    end else begin
                        data_nxt          = FILL_WORD;
                        underrun_set[idx] = 1'b1;
                    end
                    if (idx == 2'd3) state_nxt = enable ? SYNC : IDLE;
                    idx_nxt = idx + 2'd1;
                end
                default: state_nxt = IDLE;
            endcase
        end
        // A new underrun wins over a clear arriving in the same cycle.
        underrun_nxt = (clr_status ? 4'b0000 : underrun) | underrun_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_slot  <= 2'd0;
            frame_cnt <= 16'd0;
            underrun  <= 4'b0000;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_sof   <= sof_nxt;
            out_slot  <= slot_nxt;
            frame_cnt <= cnt_nxt;
            underrun  <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_tx_tdm_frame_scheduler.sv
// Directed bench for tx_tdm_frame_scheduler: frame order, underrun flags, stalls,
// enable handling, mid-frame reset and frame counter wrap.
module tb_tx_tdm_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  in_valid = 4'b0;
    logic [15:0] in_data0 = 16'h0, in_data1 = 16'h0, in_data2 = 16'h0, in_data3 = 16'h0;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sof;
    logic [1:0]  out_slot;
    logic        out_ready = 1'b1;
    logic [15:0] frame_cnt;
    logic [3:0]  underrun;
    logic        clr_status = 1'b0;

    int errors = 0;
    int checks = 0;

    tx_tdm_frame_scheduler dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
        .out_slot(out_slot), .out_ready(out_ready), .frame_cnt(frame_cnt),
        .underrun(underrun), .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        enable = 1'b0; in_valid = 4'b0; out_ready = 1'b1; clr_status = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic load_data();
        in_data0 = 16'h1111; in_data1 = 16'h2222; in_data2 = 16'h3333; in_data3 = 16'h4444;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0000", out_data); end
        checks++; if (out_sof !== 1'b0 || out_slot !== 2'd0) begin errors++; $display("[TB] FAIL reset_sof_slot: got %b/%0d want 0/0", out_sof, out_slot); end
        checks++; if (frame_cnt !== 16'h0 || underrun !== 4'h0) begin errors++; $display("[TB] FAIL reset_cnt_ur: got %h/%b want 0000/0000", frame_cnt, underrun); end
        checks++; if (in_ready !== 4'h0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 0000", in_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        logic [15:0] exp_d   [6] = '{16'hA5A5, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hA5A5};
        logic [3:0]  exp_r   [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        logic        exp_sof [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  exp_slot[6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        load_data(); in_valid = 4'hF; enable = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_prevalid: got %b want 0", out_valid); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (in_ready !== exp_r[k]) begin errors++; $display("[TB] FAIL basic_in_ready[%0d]: got %b want %b", k, in_ready, exp_r[k]); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d[k]) begin errors++; $display("[TB] FAIL basic_word[%0d]: got v=%b %h want v=1 %h", k, out_valid, out_data, exp_d[k]); end
            checks++; if (out_sof !== exp_sof[k] || out_slot !== exp_slot[k]) begin errors++; $display("[TB] FAIL basic_sof_slot[%0d]: got %b/%0d want %b/%0d", k, out_sof, out_slot, exp_sof[k], exp_slot[k]); end
            if (k == 0) begin
                checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL basic_cnt1: got %0d want 1", frame_cnt); end
            end
            if (k == 5) begin
                checks++; if (frame_cnt !== 16'd2) begin errors++; $display("[TB] FAIL basic_cnt2: got %0d want 2", frame_cnt); end
            end
        end
    endtask

    task automatic test_underrun();
        apply_reset();
        load_data(); in_valid = 4'b1011; enable = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("[TB] FAIL ur_in_ready: got %b want 0100", in_ready); end
        tick();
        checks++; if (out_data !== 16'h0000 || out_slot !== 2'd2) begin errors++; $display("[TB] FAIL ur_fill: got %h slot %0d want 0000 slot 2", out_data, out_slot); end
        checks++; if (underrun !== 4'b0100) begin errors++; $display("[TB] FAIL ur_set: got %b want 0100", underrun); end
        tick();
        checks++; if (out_data !== 16'h4444) begin errors++; $display("[TB] FAIL ur_slot3: got %h want 4444", out_data); end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checks++; if (underrun !== 4'b0000) begin errors++; $display("[TB] FAIL ur_clear: got %b want 0000", underrun); end
        tick(); tick(); tick();
        checks++; if (underrun !== 4'b0100) begin errors++; $display("[TB] FAIL ur_reset_again: got %b want 0100", underrun); end
        tick(); tick(); tick(); tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checks++; if (underrun !== 4'b0100) begin errors++; $display("[TB] FAIL ur_set_priority: got %b want 0100", underrun); end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_d[3] = '{16'h3333, 16'h4444, 16'hA5A5};
        apply_reset();
        load_data(); in_valid = 4'hF; enable = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (out_data !== 16'h2222 || out_slot !== 2'd1) begin errors++; $display("[TB] FAIL bp_slot1: got %h slot %0d want 2222 slot 1", out_data, out_slot); end
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0000", k, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 16'h2222 || out_slot !== 2'd1) begin errors++; $display("[TB] FAIL bp_hold[%0d]: got v=%b %h slot %0d want v=1 2222 slot 1", k, out_valid, out_data, out_slot); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("[TB] FAIL bp_resume_ready: got %b want 0100", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (out_data !== exp_d[k]) begin errors++; $display("[TB] FAIL bp_after[%0d]: got %h want %h", k, out_data, exp_d[k]); end
        end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("[TB] FAIL bp_cnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_enable_drop();
        apply_reset();
        load_data(); in_valid = 4'hF; enable = 1'b1;
        tick(); tick(); tick(); tick();
        enable = 1'b0;
        tick();
        checks++; if (out_data !== 16'h3333 || out_slot !== 2'd2) begin errors++; $display("[TB] FAIL en_slot2: got %h slot %0d want 3333 slot 2", out_data, out_slot); end
        tick();
        checks++; if (out_data !== 16'h4444 || out_slot !== 2'd3) begin errors++; $display("[TB] FAIL en_slot3: got %h slot %0d want 4444 slot 3", out_data, out_slot); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL en_idle_valid: got %b want 0", out_valid); end
        tick(); tick();
        checks++; if (out_valid !== 1'b0 || frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL en_idle_hold: got v=%b cnt=%0d want v=0 cnt=1", out_valid, frame_cnt); end
        enable = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL en_restart_gap: got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || out_sof !== 1'b1) begin errors++; $display("[TB] FAIL en_restart_sync: got v=%b %h sof=%b want v=1 a5a5 sof=1", out_valid, out_data, out_sof); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("[TB] FAIL en_restart_cnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        load_data(); in_valid = 4'b1011; enable = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        checks++; if (out_slot !== 2'd2 || underrun !== 4'b0100) begin errors++; $display("[TB] FAIL mr_pre: got slot %0d ur %b want slot 2 ur 0100", out_slot, underrun); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sof !== 1'b0 || out_slot !== 2'd0) begin errors++; $display("[TB] FAIL mr_outputs: got v=%b %h sof=%b slot %0d want all 0", out_valid, out_data, out_sof, out_slot); end
        checks++; if (frame_cnt !== 16'h0 || underrun !== 4'h0 || in_ready !== 4'h0) begin errors++; $display("[TB] FAIL mr_status: got cnt=%h ur=%b rdy=%b want 0", frame_cnt, underrun, in_ready); end
        #2 rst_n = 1'b1;
        in_valid = 4'hF;
        tick(); tick();
        checks++; if (out_data !== 16'hA5A5 || out_sof !== 1'b1 || frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL mr_restart: got %h sof=%b cnt=%0d want a5a5 sof=1 cnt=1", out_data, out_sof, frame_cnt); end
    endtask

    task automatic test_wrap();
        apply_reset();
        load_data(); in_valid = 4'hF;
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        enable = 1'b1;
        tick(); tick();
        checks++; if (out_sof !== 1'b1 || frame_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL wrap: got sof=%b cnt=%h want sof=1 cnt=0000", out_sof, frame_cnt); end
        tick();
        checks++; if (out_data !== 16'h1111 || frame_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_next: got %h cnt=%h want 1111 cnt=0000", out_data, frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_backpressure();
        test_enable_drop();
        test_reset_midframe();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
